// File: rtl/mul_dot_seq_if.sv
// Handshake bundle between the dot-product sequencer and the serial multiplier.
// master = sequencer side, slave = multiplier side.
interface mul_dot_seq_if #(
  parameter int D_W = 16
);
  logic           O_MUL_VLD;
  logic [D_W-1:0] O_MUL_M1;
  logic [D_W-1:0] O_MUL_M2;
  logic           I_MUL_VLD;
  logic           I_MUL_BUSY;
  logic [D_W-1:0] I_PRODUCT;

  modport master (
    output O_MUL_VLD, O_MUL_M1, O_MUL_M2,
    input  I_MUL_VLD, I_MUL_BUSY, I_PRODUCT
  );

  modport slave (
    input  O_MUL_VLD, O_MUL_M1, O_MUL_M2,
    output I_MUL_VLD, I_MUL_BUSY, I_PRODUCT
  );
endinterface

// File: rtl/mul_dot_seq.sv
// Dot-product sequencer: feeds element pairs to a serial fixed-point multiplier
// one at a time, accumulates the products at full width and emits one
// saturated D_W-bit result with a one-cycle valid pulse.
module mul_dot_seq #(
  parameter int D_W     = 16,
  parameter int VEC_LEN = 8
) (
  input  logic                   I_CLK,
  input  logic                   I_RST_N,
  input  logic                   I_START,
  input  logic [D_W*VEC_LEN-1:0] I_VEC_A,
  input  logic [D_W*VEC_LEN-1:0] I_VEC_B,
  output logic                   O_BUSY,
  output logic                   O_VLD,
  output logic [D_W-1:0]         O_DOT,
  output logic                   O_SAT,
  mul_dot_seq_if.master          mul
);

  localparam int IDX_W = $clog2(VEC_LEN);
  // Enough headroom that summing VEC_LEN full-scale products never wraps.
  localparam int ACC_W = D_W + $clog2(VEC_LEN);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (D_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(1 << (D_W-1)));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                idx;
  logic signed [ACC_W-1:0]         acc;
  logic [VEC_LEN-1:0][D_W-1:0]     vec_a, vec_b;
  logic                            mul_vld;
  logic                            last;
  logic signed [ACC_W-1:0]         prod_x;
  logic signed [ACC_W-1:0]         sum_nxt;

  assign last    = (idx == IDX_W'(VEC_LEN-1));
  assign prod_x  = ACC_W'($signed(mul.I_PRODUCT));
  assign sum_nxt = acc + prod_x;

  assign O_BUSY        = (state != IDLE);
  assign mul.O_MUL_VLD = mul_vld;
  // Operands are parked at zero while idle so the multiplier bus is quiet.
  assign mul.O_MUL_M1  = (state == IDLE) ? '0 : vec_a[idx];
  assign mul.O_MUL_M2  = (state == IDLE) ? '0 : vec_b[idx];

  // State register.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and issue strobe; ISSUE stalls for as long as the multiplier is busy.
  always_comb begin
    state_nxt = state;
    mul_vld   = 1'b0;
    case (state)
      IDLE:  if (I_START) state_nxt = ISSUE;
      ISSUE: begin
        mul_vld = !mul.I_MUL_BUSY;
        if (mul_vld) state_nxt = WAIT;
      end
      WAIT:  if (mul.I_MUL_VLD) state_nxt = last ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: vector capture, element index, accumulation and saturated result.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      vec_a <= '0;
      vec_b <= '0;
      idx   <= '0;
      acc   <= '0;
      O_VLD <= 1'b0;
      O_DOT <= '0;
      O_SAT <= 1'b0;
    end else begin
      O_VLD <= 1'b0;
      case (state)
        IDLE: if (I_START) begin
          vec_a <= I_VEC_A;
          vec_b <= I_VEC_B;
          idx   <= '0;
          acc   <= '0;
        end
        WAIT: if (mul.I_MUL_VLD) begin
          acc <= sum_nxt;
          if (last) begin
            O_VLD <= 1'b1;
            if (sum_nxt > SMAX) begin
              O_DOT <= {1'b0, {(D_W-1){1'b1}}};
              O_SAT <= 1'b1;
            end else if (sum_nxt < SMIN) begin
              O_DOT <= {1'b1, {(D_W-1){1'b0}}};
              O_SAT <= 1'b1;
            end else begin
              O_DOT <= sum_nxt[D_W-1:0];
              O_SAT <= 1'b0;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_dot_seq.sv
// Directed bench for mul_dot_seq with a behavioural Q2.13 serial multiplier.
module tb_mul_dot_seq;
  localparam int D_W     = 16;
  localparam int VEC_LEN = 8;
  localparam int LAT     = VEC_LEN * (D_W + 1);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [D_W*VEC_LEN-1:0] vec_a = '0;
  logic [D_W*VEC_LEN-1:0] vec_b = '0;
  logic                   busy, vld, sat;
  logic [D_W-1:0]         dot;

  int checks = 0;
  int errors = 0;

  mul_dot_seq_if #(.D_W(D_W)) mif();

  mul_dot_seq #(.D_W(D_W), .VEC_LEN(VEC_LEN)) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .I_START (start),
    .I_VEC_A (vec_a),
    .I_VEC_B (vec_b),
    .O_BUSY  (busy),
    .O_VLD   (vld),
    .O_DOT   (dot),
    .O_SAT   (sat),
    .mul     (mif)
  );

  always #5 clk = ~clk;

  // Serial multiplier model: busy D_W cycles after accept, result valid in the last busy cycle.
  int                 mcnt;
  logic [D_W-1:0]     mprod;
  wire signed [31:0]  mp = $signed(mif.O_MUL_M1) * $signed(mif.O_MUL_M2);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt  <= 0;
      mprod <= '0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end else if (mif.O_MUL_VLD) begin
      mcnt  <= D_W;
      mprod <= mp[28:13];
    end
  end
  assign mif.I_MUL_BUSY = (mcnt != 0);
  assign mif.I_MUL_VLD  = (mcnt == 1);
  assign mif.I_PRODUCT  = mprod;

  // Issue monitor: total accepted issues and issues made while the multiplier was busy.
  int issues_tot = 0;
  int viol_tot   = 0;
  always @(posedge clk) begin
    if (rst_n && mif.O_MUL_VLD) begin
      issues_tot = issues_tot + 1;
      if (mif.I_MUL_BUSY) viol_tot = viol_tot + 1;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [15:0] dot;
    logic        sat;
  } vec_t;

  vec_t tv[8];
  int   iss_base, viol_base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_vecs(input logic [15:0] a, input logic [15:0] b0, input logic [15:0] b1);
    for (int i = 0; i < VEC_LEN; i++) begin
      vec_a[i*D_W +: D_W] = a;
      vec_b[i*D_W +: D_W] = i[0] ? b1 : b0;
    end
  endtask

  // Called at posedge+1; I_START is sampled on the next edge (edge 0).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b0, input logic [15:0] b1);
    set_vecs(a, b0, b1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    iss_base  = issues_tot;
    viol_base = viol_tot;
  endtask

  // Waits for O_VLD (bounded) and checks latency, result and issue behaviour.
  // inj>0 pulses a competing I_START with other vectors at that cycle.
  task automatic wait_result(input string nm, input logic [15:0] ed, input logic es, input int inj);
    int  n = 0;
    bit  got = 0;
    while (!got && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == inj);
      if (n == inj) set_vecs(16'h7FFF, 16'h7FFF, 16'h7FFF);
      if (vld) got = 1;
    end
    start = 1'b0;
    chk({nm, " latency"}, n, LAT);
    chk({nm, " dot"}, {16'h0, dot}, {16'h0, ed});
    chk({nm, " sat"}, {31'h0, sat}, {31'h0, es});
    chk({nm, " busy_low"}, {31'h0, busy}, 32'h0);
    chk({nm, " issues"}, issues_tot - iss_base, VEC_LEN);
    chk({nm, " issue_while_busy"}, viol_tot - viol_base, 0);
  endtask

  initial begin
    tv[0] = '{16'h2000, 16'h0400, 16'h0400, 16'h2000, 1'b0};  // 8 * 0.125 = 1.0
    tv[1] = '{16'h2000, 16'hFC00, 16'hFC00, 16'hE000, 1'b0};  // -1.0
    tv[2] = '{16'h2000, 16'h1000, 16'h1000, 16'h7FFF, 1'b1};  // 4.0 saturates high
    tv[3] = '{16'h2000, 16'hE000, 16'hE000, 16'h8000, 1'b1};  // -8.0 saturates low
    tv[4] = '{16'h2000, 16'h1000, 16'hF000, 16'h0000, 1'b0};  // alternating signs cancel
    tv[5] = '{16'h2000, 16'h0FFF, 16'h0FFF, 16'h7FF8, 1'b0};  // just below max, no sat
    tv[6] = '{16'h2000, 16'hF000, 16'hF000, 16'h8000, 1'b0};  // exactly -4.0, no sat
    tv[7] = '{16'hF000, 16'h0400, 16'h0400, 16'hF000, 1'b0};  // -0.5*0.125*8 = -0.5

    // Reset state
    #12;
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst vld", {31'h0, vld}, 32'h0);
    chk("rst dot", {16'h0, dot}, 32'h0);
    chk("rst sat", {31'h0, sat}, 32'h0);
    chk("rst mul_vld", {31'h0, mif.O_MUL_VLD}, 32'h0);
    chk("rst mul_m1", {16'h0, mif.O_MUL_M1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors; even entries chain back-to-back from the O_VLD cycle.
    for (int i = 0; i < 8; i++) begin
      start_op(tv[i].a, tv[i].b0, tv[i].b1);
      wait_result($sformatf("v%0d", i), tv[i].dot, tv[i].sat, 0);
      if (i[0]) begin
        @(posedge clk);
        #1;
        chk($sformatf("v%0d vld_pulse", i), {31'h0, vld}, 32'h0);
        chk($sformatf("v%0d dot_hold", i), {16'h0, dot}, {16'h0, tv[i].dot});
        chk($sformatf("v%0d idle_m1", i), {16'h0, mif.O_MUL_M1}, 32'h0);
      end
    end

    // Competing I_START at cycle 50 is ignored
    start_op(16'h2000, 16'h0400, 16'h0400);
    wait_result("ign_start", 16'h2000, 1'b0, 50);
    // Back-to-back start in the O_VLD cycle
    start_op(16'h2000, 16'hFC00, 16'hFC00);
    wait_result("b2b", 16'hE000, 1'b0, 0);

    // Reset mid-operation at cycle 70 for 2 cycles
    start_op(16'h2000, 16'h0400, 16'h0400);
    repeat (70) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", {31'h0, busy}, 32'h0);
    chk("mid_rst dot", {16'h0, dot}, 32'h0);
    chk("mid_rst mul_vld", {31'h0, mif.O_MUL_VLD}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      int pulses = 0;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        #1;
        if (vld) pulses++;
      end
      chk("mid_rst no_vld", pulses, 0);
      chk("mid_rst idle", {31'h0, busy}, 32'h0);
      chk("mid_rst dot_zero", {16'h0, dot}, 32'h0);
    end
    start_op(16'h2000, 16'h1000, 16'hF000);
    wait_result("post_rst", 16'h0000, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
